icache_dm: RTL and testbench

//  Direct-mapped instruction cache between the program counter / IR fetch path and the 256x16 instruction RAM.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/icache_line_store.sv | 59 +++++
 rtl/icache_dm.sv | 162 ++++++++++++++++
 tb/tb_icache_dm.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Types and sizing shared by the instruction cache, and by a future data cache
//   with an 8-bit word.
//   - cache_state_e : controller states (IDLE, FILL, WRITE)
//   - IDX_W / TAG_W : address split for the default geometry (256 words, 4 lines)
//   - CNT_W         : width of the hit/miss statistics counters
//   - sat_inc()     : increment that sticks at all-ones
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 8;
  localparam int LINES_DEF   = 4;
  localparam int IDX_W       = $clog2(LINES_DEF);
  localparam int TAG_W       = A_WIDTH_DEF - IDX_W;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_e;

  // Statistics counters hold at their maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// -----------------------------------------------------------------------------
// icache_line_store
//   Storage for a direct-mapped cache with one word per line: a valid bit, a
//   tag and a data word per line. One combinational lookup port (data + hit)
//   and one synchronous write port. Only the valid bits are reset, so an
//   aborted fill can never leave a usable line behind.
//   Ports:
//     g_clk, g_clr          clock, asynchronous active-low clear of valid bits
//     rd_idx_i, rd_tag_i    lookup address split into index and tag
//     rd_data_o, hit_o      data of the indexed line, valid && tag match
//     we_i                  write enable (sets valid for the written line)
//     wr_idx_i, wr_tag_i    line to write and tag to store
//     wr_data_i             data word to store
// -----------------------------------------------------------------------------
module icache_line_store
  import cache_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int IDX_BITS = IDX_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                g_clk,
  input  logic                g_clr,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  output logic [D_WIDTH-1:0]  rd_data_o,
  output logic                hit_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [D_WIDTH-1:0]  wr_data_i
);

  localparam int NLINES = 1 << IDX_BITS;

  logic [NLINES-1:0]   valid_q;
  logic [TAG_BITS-1:0] tag_q  [NLINES];
  logic [D_WIDTH-1:0]  data_q [NLINES];

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are never observed while valid is low.
  always_ff @(posedge g_clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = data_q[rd_idx_i];
  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
//   Direct-mapped instruction cache between the fetch path and the instruction
//   RAM. Read hits complete in the cycle they are presented (odv=1); a read miss
//   drops odv, fetches the word from RAM for MEM_LAT cycles and retries the
//   lookup, which then hits. Writes go straight through to RAM in a one-cycle
//   WRITE state and update the cached copy only if the line already holds that
//   address (no allocation on write).
//   Ports:
//     g_clk, g_clr             clock, asynchronous active-low reset
//     cpu_addr, cpu_wdata      fetch/write address and program-load data
//     cpu_rd, cpu_wr           read / write request (write wins if both)
//     cpu_rdata, odv           instruction word, data valid / op complete
//     mem_addr, mem_wdata      registered address and write data to RAM
//     mem_rdata                RAM read data
//     mem_rd, mem_wr           registered RAM read / write enables
//     hit_cnt, miss_cnt        saturating read statistics
// -----------------------------------------------------------------------------
module icache_dm
  import cache_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int LINES   = LINES_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               odv,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = A_WIDTH - IDX_BITS;
  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  cache_state_e       state_q;
  logic [LAT_W-1:0]   lat_q;
  logic               wr_hit_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic [A_WIDTH-1:0] mem_addr_q;
  logic [D_WIDTH-1:0] mem_wdata_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;

  logic               lk_hit;
  logic [D_WIDTH-1:0] lk_data;
  logic               ls_we;
  logic [D_WIDTH-1:0] ls_wdata;

  // The latched request address (mem_addr_q) drives the line write port, so
  // cpu_addr moving during a fill cannot redirect where the word lands.
  assign ls_we    = ((state_q == FILL) && (lat_q == '0)) ||
                    ((state_q == WRITE) && wr_hit_q);
  assign ls_wdata = (state_q == FILL) ? mem_rdata : mem_wdata_q;

  icache_line_store #(
    .D_WIDTH  (D_WIDTH),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_store (
    .g_clk     (g_clk),
    .g_clr     (g_clr),
    .rd_idx_i  (cpu_addr[IDX_BITS-1:0]),
    .rd_tag_i  (cpu_addr[A_WIDTH-1:IDX_BITS]),
    .rd_data_o (lk_data),
    .hit_o     (lk_hit),
    .we_i      (ls_we),
    .wr_idx_i  (mem_addr_q[IDX_BITS-1:0]),
    .wr_tag_i  (mem_addr_q[A_WIDTH-1:IDX_BITS]),
    .wr_data_i (ls_wdata)
  );

  // odv is combinational so a miss or write can stall fetch in the very cycle
  // it is presented.
  always_comb begin
    odv       = 1'b0;
    cpu_rdata = '0;
    if (state_q == IDLE) begin
      odv = !cpu_wr && !(cpu_rd && !lk_hit);
      if (lk_hit) begin
        cpu_rdata = lk_data;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      wr_hit_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_wr) begin
            state_q     <= WRITE;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
            // Remember whether the cached copy must follow the RAM write.
            wr_hit_q    <= lk_hit;
          end else if (cpu_rd) begin
            if (lk_hit) begin
              hit_cnt_q <= sat_inc(hit_cnt_q);
            end else begin
              state_q    <= FILL;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= cpu_addr;
              lat_q      <= LAT_W'(MEM_LAT - 1);
              miss_cnt_q <= sat_inc(miss_cnt_q);
            end
          end
        end
        FILL: begin
          // The line is written on the last FILL edge (see ls_we).
          if (lat_q == '0) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        WRITE: begin
          state_q  <= IDLE;
          mem_wr_q <= 1'b0;
          wr_hit_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm
//   Two cache instances: dut0 with MEM_LAT=1 and dut1 with MEM_LAT=3, each with
//   its own instruction RAM model whose read data is only valid on the last
//   cycle of the expected latency. RAM word a initially holds {8'hA5, a}.
//   Stimulus pushes expected read words / RAM writes into queues; a monitor
//   pops and compares whenever a read completes (cpu_rd && odv) or mem_wr fires.
// -----------------------------------------------------------------------------
module tb_icache_dm;

  typedef struct {
    int          k;
    logic [15:0] data;
    int          stall;
  } rd_exp_t;

  typedef struct {
    int          k;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        clr_n     [2];
  logic [7:0]  cpu_addr  [2];
  logic [15:0] cpu_wdata [2];
  logic        cpu_rd    [2];
  logic        cpu_wr    [2];
  logic [15:0] cpu_rdata [2];
  logic        odv       [2];
  logic [7:0]  mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [7:0]  hit_cnt   [2];
  logic [7:0]  miss_cnt  [2];

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int checks = 0;
  int errors = 0;
  int exp_hit   [2] = '{0, 0};
  int exp_miss  [2] = '{0, 0};
  int exp_rdcyc [2] = '{0, 0};
  int rdcyc     [2] = '{0, 0};
  int stall_c   [2] = '{0, 0};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT_G = (gi == 0) ? 1 : 3;
      logic [15:0] ram [256];
      int          rd_run = 0;

      // RAM is (re)loaded while its cache is held in reset.
      always @(posedge clk) begin
        if (!clr_n[gi]) begin
          for (int a = 0; a < 256; a++) ram[a] <= {8'hA5, 8'(a)};
        end else if (mem_wr[gi]) begin
          ram[mem_addr[gi]] <= mem_wdata[gi];
        end
      end

      always @(posedge clk) begin
        if (mem_rd[gi]) rd_run <= rd_run + 1;
        else            rd_run <= 0;
      end

      assign mem_rdata[gi] = (mem_rd[gi] && rd_run == LAT_G - 1) ? ram[mem_addr[gi]] : 16'hDEAD;

      icache_dm #(
        .D_WIDTH (16),
        .A_WIDTH (8),
        .LINES   (4),
        .MEM_LAT (LAT_G)
      ) u_dut (
        .g_clk     (clk),
        .g_clr     (clr_n[gi]),
        .cpu_addr  (cpu_addr[gi]),
        .cpu_wdata (cpu_wdata[gi]),
        .cpu_rd    (cpu_rd[gi]),
        .cpu_wr    (cpu_wr[gi]),
        .cpu_rdata (cpu_rdata[gi]),
        .odv       (odv[gi]),
        .mem_addr  (mem_addr[gi]),
        .mem_wdata (mem_wdata[gi]),
        .mem_rdata (mem_rdata[gi]),
        .mem_rd    (mem_rd[gi]),
        .mem_wr    (mem_wr[gi]),
        .hit_cnt   (hit_cnt[gi]),
        .miss_cnt  (miss_cnt[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!clr_n[k]) begin
          stall_c[k] = 0;
        end else begin
          if (mem_rd[k]) rdcyc[k]++;
          chk("rd_wr_excl", k, {31'b0, mem_rd[k] & mem_wr[k]}, 32'd0);
          if (mem_wr[k]) begin
            if (wr_q.size() == 0) begin
              chk("unexpected_mem_wr", k, {24'b0, mem_addr[k]}, 32'hFFFF_FFFF);
            end else begin
              we = wr_q.pop_front();
              chk("wr_dut", k, k, we.k);
              chk("wr_addr", k, {24'b0, mem_addr[k]}, {24'b0, we.addr});
              chk("wr_data", k, {16'b0, mem_wdata[k]}, {16'b0, we.data});
              $display("memwr dut%0d addr=%h data=%h", k, mem_addr[k], mem_wdata[k]);
            end
          end
          if (cpu_rd[k] && !cpu_wr[k]) begin
            if (odv[k]) begin
              if (rd_q.size() == 0) begin
                chk("unexpected_read", k, {16'b0, cpu_rdata[k]}, 32'hFFFF_FFFF);
              end else begin
                re = rd_q.pop_front();
                chk("rd_dut", k, k, re.k);
                chk("rd_data", k, {16'b0, cpu_rdata[k]}, {16'b0, re.data});
                chk("rd_stall", k, stall_c[k], re.stall);
                $display("read dut%0d addr=%h data=%h stall=%0d", k, cpu_addr[k], cpu_rdata[k], stall_c[k]);
              end
              stall_c[k] = 0;
            end else begin
              stall_c[k]++;
            end
          end
        end
      end
    end
  end

  // Read a0; if it stalls, cpu_addr moves to a1 one cycle later.
  task automatic rd(input int k, input logic [7:0] a0, input logic [7:0] a1,
                    input logic [15:0] exp_d, input int exp_st);
    bit done;
    int n;
    int misses;
    misses = exp_st / (lat_of(k) + 1);
    rd_q.push_back('{k: k, data: exp_d, stall: exp_st});
    exp_miss[k]  = sat8(exp_miss[k] + misses);
    exp_hit[k]   = sat8(exp_hit[k] + 1);
    exp_rdcyc[k] = exp_rdcyc[k] + misses * lat_of(k);
    cpu_addr[k] = a0;
    cpu_rd[k]   = 1'b1;
    cpu_wr[k]   = 1'b0;
    done = 1'b0;
    n    = 0;
    @(negedge clk);
    if (odv[k]) done = 1'b1;
    if (!done) begin
      @(posedge clk);
      #1 cpu_addr[k] = a1;
    end
    while (!done && n < 40) begin
      @(negedge clk);
      if (odv[k]) done = 1'b1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout dut%0d: no odv for addr %h within 40 cycles", k, a0);
      if (rd_q.size() > 0) void'(rd_q.pop_back());
    end
    @(posedge clk);
    #1 cpu_rd[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [7:0] a, input logic [15:0] d, input logic also_rd);
    wr_q.push_back('{k: k, addr: a, data: d});
    cpu_addr[k]  = a;
    cpu_wdata[k] = d;
    cpu_wr[k]    = 1'b1;
    cpu_rd[k]    = also_rd;
    @(negedge clk);
    chk("wr_accept_odv", k, {31'b0, odv[k]}, 32'd0);
    @(posedge clk);
    #1;
    cpu_wr[k] = 1'b0;
    cpu_rd[k] = 1'b0;
    @(negedge clk);
    chk("wr_state_odv", k, {31'b0, odv[k]}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wr_done_odv", k, {31'b0, odv[k]}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_chk(input int k);
    @(negedge clk);
    chk("hit_cnt", k, {24'b0, hit_cnt[k]}, exp_hit[k]);
    chk("miss_cnt", k, {24'b0, miss_cnt[k]}, exp_miss[k]);
    chk("mem_rd_cycles", k, rdcyc[k], exp_rdcyc[k]);
    $display("counters dut%0d hit=%0d miss=%0d mem_rd_cycles=%0d", k, hit_cnt[k], miss_cnt[k], rdcyc[k]);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input int k);
    chk("rst_odv", k, {31'b0, odv[k]}, 32'd1);
    chk("rst_rdata", k, {16'b0, cpu_rdata[k]}, 32'd0);
    chk("rst_mem_rd", k, {31'b0, mem_rd[k]}, 32'd0);
    chk("rst_mem_wr", k, {31'b0, mem_wr[k]}, 32'd0);
    chk("rst_mem_addr", k, {24'b0, mem_addr[k]}, 32'd0);
    chk("rst_mem_wdata", k, {16'b0, mem_wdata[k]}, 32'd0);
    chk("rst_hit_cnt", k, {24'b0, hit_cnt[k]}, 32'd0);
    chk("rst_miss_cnt", k, {24'b0, miss_cnt[k]}, 32'd0);
    $display("reset check dut%0d done", k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr_n[k]     = 1'b0;
      cpu_addr[k]  = 8'h00;
      cpu_wdata[k] = 16'h0000;
      cpu_rd[k]    = 1'b0;
      cpu_wr[k]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk(0);
    rst_chk(1);
    @(posedge clk);
    #1;
    clr_n[0] = 1'b1;
    clr_n[1] = 1'b1;

    // Cold miss, then hit, conflict miss on the same index, and back.
    rd(0, 8'h00, 8'h00, 16'hA500, 2);
    cnt_chk(0);
    rd(0, 8'h00, 8'h00, 16'hA500, 0);
    rd(0, 8'h04, 8'h04, 16'hA504, 2);
    rd(0, 8'h00, 8'h00, 16'hA500, 2);
    cnt_chk(0);

    // Write-through: hit updates the line, miss leaves it alone.
    rd(0, 8'h01, 8'h01, 16'hA501, 2);
    rd(0, 8'h01, 8'h01, 16'hA501, 0);
    wr(0, 8'h01, 16'hBEEF, 1'b0);
    rd(0, 8'h01, 8'h01, 16'hBEEF, 0);
    wr(0, 8'h09, 16'h1234, 1'b0);
    rd(0, 8'h01, 8'h01, 16'hBEEF, 0);
    rd(0, 8'h09, 8'h09, 16'h1234, 2);
    rd(0, 8'h01, 8'h01, 16'hBEEF, 2);
    cnt_chk(0);

    // Simultaneous read and write: write wins, no fill, no allocation.
    wr(0, 8'h02, 16'h5555, 1'b1);
    cnt_chk(0);
    rd(0, 8'h02, 8'h02, 16'h5555, 2);
    cnt_chk(0);

    // Hit counter saturation.
    for (int i = 0; i < 300; i++) rd(0, 8'h00, 8'h00, 16'hA500, 0);
    cnt_chk(0);
    chk("hit_cnt_sat", 0, {24'b0, hit_cnt[0]}, 32'hFF);

    // MEM_LAT=3: address moves mid-fill, original fill still lands.
    rd(1, 8'h10, 8'h23, 16'hA523, 8);
    rd(1, 8'h10, 8'h10, 16'hA510, 0);
    rd(1, 8'h23, 8'h23, 16'hA523, 0);
    cnt_chk(1);

    // Reset in the middle of a fill.
    cpu_addr[1] = 8'h31;
    cpu_rd[1]   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr_n[1]  = 1'b0;
    cpu_rd[1] = 1'b0;
    exp_rdcyc[1] = exp_rdcyc[1] + 1;
    exp_hit[1]   = 0;
    exp_miss[1]  = 0;
    #2;
    rst_chk(1);
    @(posedge clk);
    #1 clr_n[1] = 1'b1;
    rd(1, 8'h10, 8'h10, 16'hA510, 4);
    rd(1, 8'h23, 8'h23, 16'hA523, 4);
    rd(1, 8'h31, 8'h31, 16'hA531, 4);
    cnt_chk(1);

    chk("rd_queue_empty", 0, rd_q.size(), 32'd0);
    chk("wr_queue_empty", 0, wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
